jk_cmd_seq: RTL and testbench
=============================

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have parameter LEN_W, default 4, width of the per-command drive length.
REQ-003 Port: clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: cmd_valid  input  1  command offered this cycle.
REQ-006 Port: cmd_op  input  2  operation: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 Port: cmd_len  input  LEN_W  number of drive cycles; 0 is treated as 1.
REQ-008 Port: cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-009 Port: j  output  1  registered J drive to the downstream JK flip-flop.
REQ-010 Port: k  output  1  registered K drive to the downstream JK flip-flop.
REQ-011 Port: q_fb  input  1  Q fed back from the downstream JK flip-flop.
REQ-012 Port: busy  output  1  FIFO non-empty or a command is being driven.
REQ-013 Port: done  output  1  single-cycle pulse, last drive cycle of a command.
REQ-014 Port: err  output  1  sticky Q-mismatch flag.

Function
REQ-015 A command SHALL be pushed at a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 0 exactly when the FIFO holds DEPTH entries.
REQ-016 The FSM SHALL have states IDLE and DRIVE; IDLE moves to DRIVE by popping the FIFO head at the first edge where the FIFO is non-empty.
REQ-017 In DRIVE, j/k SHALL be 00 hold, 01 reset, 10 set, 11 toggle for the popped op, held for max(cmd_len,1) consecutive cycles.
REQ-018 In IDLE, j and k SHALL be 0 (hold).
REQ-019 Latency: a command pushed at edge N into an empty FIFO while IDLE SHALL drive j/k from edge N+1.
REQ-020 On the last drive cycle, done SHALL be 1; if the FIFO is non-empty the next command SHALL be popped at the same edge, with no IDLE gap.
REQ-021 A push and a pop at the same edge SHALL both take effect, leaving the occupancy unchanged.
REQ-022 cmd_valid while cmd_ready is 0 SHALL be ignored, with no FIFO corruption.
REQ-023 busy SHALL equal (state==DRIVE) OR (FIFO non-empty).

Reset
REQ-024 rst high SHALL immediately, without waiting for clk, clear the FIFO and set the state to IDLE.
REQ-025 During reset, outputs SHALL be j=0, k=0, cmd_ready=1, busy=0, done=0, err=0, and the expected-Q model SHALL be 0.
REQ-026 Reset asserted mid-command SHALL abandon that command and all queued commands; no done pulse SHALL be produced for them.

Configuration
REQ-027 With macro JKSEQ_CHECK_EN defined, the block SHALL keep an expected-Q model updated per drive cycle by JK rules.
REQ-028 With JKSEQ_CHECK_EN defined, the block SHALL compare q_fb against the model two edges after each drive cycle, setting err on mismatch.
REQ-029 With JKSEQ_CHECK_EN defined, err SHALL stay set until reset.
REQ-030 Without JKSEQ_CHECK_EN, the model and comparator SHALL be absent, err SHALL be constant 0, and q_fb SHALL be unused.

Verification
REQ-031 Reset, then push op=10 len=3 -> j=1,k=0 for 3 cycles starting 1 edge after push; done high on the 3rd cycle; then j=k=0 and busy=0.
REQ-032 Push op=11 len=0 -> exactly 1 cycle of j=k=1, with done high on that cycle.
REQ-033 Push 5 commands back-to-back with DEPTH=4 and the FSM busy on a long command -> cmd_ready drops after the 4th queued entry; a 5th held valid is accepted after the next pop; all ops are driven in order with no gaps.
REQ-034 Assert rst mid-way through a len=8 set command with 2 queued commands -> j=k=0 at once, busy=0, and no further drive after release.
REQ-035 JKSEQ_CHECK_EN defined, ideal JK FF model attached: push set/toggle/reset sequences -> err stays 0; force q_fb wrong for one cycle -> err=1 and stays 1 until rst.
REQ-036 JKSEQ_CHECK_EN undefined: drive arbitrary q_fb -> err=0 throughout.

Source files
------------

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: queued command sequencer for a downstream JK flip-flop.
//
// Commands (op, len) are pushed into a DEPTH-entry FIFO. The sequencer pops
// one command at a time and holds the matching J/K pair for max(len,1)
// cycles. Back-to-back commands are driven with no idle gap.
//
// Parameters:
//   DEPTH  command FIFO depth (power of two, 2..16)
//   LEN_W  width of the per-command drive length
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command offered this cycle
//   cmd_op     00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len    drive cycles (0 treated as 1)
//   cmd_ready  FIFO can accept a command
//   j, k       registered JK drive
//   q_fb       Q fed back from the downstream flip-flop
//   busy       FIFO non-empty or a command is being driven
//   done       pulse on the last drive cycle of a command
//   err        sticky Q-mismatch flag
//
// Optional feature: define JKSEQ_CHECK_EN to build the expected-Q model and
// q_fb comparator. Without it err is tied to 0 and q_fb is ignored.

module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             j,
  output logic             k,
  input  logic             q_fb,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, DRIVE} state_t;

  logic [1:0]       op_mem  [DEPTH];
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;  // drive cycles left after the current one
  logic             j_nxt, k_nxt;
  logic             push, pop, fifo_ne;
  logic [LEN_W-1:0] head_len;

  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign fifo_ne   = (count != '0);
  assign push      = cmd_valid & cmd_ready;
  assign busy      = (state == DRIVE) | fifo_ne;
  assign done      = (state == DRIVE) & (rem == '0);
  assign head_len  = len_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    j_nxt     = j;
    k_nxt     = k;
    pop       = 1'b0;
    // A pop happens from IDLE, or on the last drive cycle, whenever the FIFO
    // has an entry; this is what gives the gap-free back-to-back behaviour.
    if (state == IDLE || rem == '0) begin
      if (fifo_ne) begin
        pop            = 1'b1;
        state_nxt      = DRIVE;
        {j_nxt, k_nxt} = op_mem[rd_ptr];
        rem_nxt        = (head_len == '0) ? '0 : head_len - 1'b1;
      end else begin
        state_nxt = IDLE;
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
        rem_nxt   = '0;
      end
    end else begin
      rem_nxt = rem - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      j     <= j_nxt;
      k     <= k_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr]  <= cmd_op;
      len_mem[wr_ptr] <= cmd_len;
    end
  end

`ifdef JKSEQ_CHECK_EN
  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    case ({jj, kk})
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~q;
      default: return q;
    endcase
  endfunction

  logic q_exp;
  logic vld_p0;

  // Stage 0: the flip-flop samples j/k at the edge ending a drive cycle; the
  // model advances at the same edge, and q_fb is compared one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_exp  <= 1'b0;
      vld_p0 <= 1'b0;
      err    <= 1'b0;
    end else begin
      vld_p0 <= (state == DRIVE);
      if (state == DRIVE) q_exp <= jk_next(q_exp, j, k);
      if (vld_p0 && (q_fb != q_exp)) err <= 1'b1;
    end
  end
`else
  logic unused_q_fb;
  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
module tb_jk_cmd_seq;

  localparam int DEPTH = 4;
  localparam int LEN_W = 4;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready;
  logic             j, k;
  logic             q_fb;
  logic             busy, done, err;

  logic q_ff;
  logic inject;

  int tests = 0;
  int fails = 0;

  jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ideal downstream JK flip-flop; inject flips the fed-back Q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_ff <= 1'b0;
    else begin
      case ({j, k})
        2'b01: q_ff <= 1'b0;
        2'b10: q_ff <= 1'b1;
        2'b11: q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end
  assign q_fb = q_ff ^ inject;

  // Reference model: queue of pending commands plus the command in flight.
  logic [5:0] mq[$];
  logic [1:0] m_op;
  int         m_rem;  // drive cycles left including the current one; 0 = idle
  logic       m_acc;
  logic       m_err;

  task automatic m_reset();
    mq.delete();
    m_op  = 2'b00;
    m_rem = 0;
    m_err = 1'b0;
    m_acc = 1'b0;
  endtask

  function automatic logic [5:0] exp_vec();
    logic ej, ek;
    ej = (m_rem > 0) && m_op[1];
    ek = (m_rem > 0) && m_op[0];
    return {ej, ek, (m_rem == 1), (m_rem > 0 || mq.size() > 0),
            (mq.size() < DEPTH), m_err};
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle 1 time unit past the edge.
  task automatic step(input logic v, input logic [1:0] op, input logic [LEN_W-1:0] len);
    logic [5:0] c;
    int l;
    cmd_valid = v;
    cmd_op    = op;
    cmd_len   = len;
    @(posedge clk);
    m_acc = v && (mq.size() < DEPTH);
    if (m_rem > 1) m_rem--;
    else if (mq.size() > 0) begin
      c     = mq.pop_front();
      m_op  = c[5:4];
      l     = int'(c[3:0]);
      m_rem = (l == 0) ? 1 : l;
    end else m_rem = 0;
    if (m_acc) mq.push_back({op, len});
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = '0; inject = 1'b0;
    m_reset();
    #2;
    tests++;
    if ({j, k, done, busy, cmd_ready, err} !== 6'b000010) begin
      fails++;
      $display("FAIL reset_state got=%b want=%b", {j, k, done, busy, cmd_ready, err}, 6'b000010);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, '0);
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
  endtask

  task automatic test_set_len3();
    step(1'b1, 2'b10, 4'd3);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step(1'b0, 2'b00, '0);
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL set_len3 cyc=%0d got=%b want=%b", i, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
  endtask

  task automatic test_toggle_len0();
    step(1'b1, 2'b11, 4'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b00, '0);
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL toggle_len0 cyc=%0d got=%b want=%b", i, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
    logic [3:0] lens[5] = '{4'd2, 4'd0, 4'd1, 4'd3, 4'd1};
    int guard;
    step(1'b1, 2'b10, 4'd15);
    for (int n = 0; n < 5; n++) begin
      guard = 0;
      do begin
        step(1'b1, ops[n], lens[n]);
        guard++;
        tests++;
        if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
          fails++;
          $display("FAIL b2b_push cmd=%0d got=%b want=%b", n, {j, k, done, busy, cmd_ready, err}, exp_vec());
        end
      end while (!m_acc && guard < 40);
      if (!m_acc) begin
        fails++;
        $display("FAIL b2b_accept cmd=%0d got=not_accepted want=accepted", n);
      end
    end
    guard = 0;
    while ((m_rem > 0 || mq.size() > 0 || busy) && guard < 60) begin
      step(1'b0, 2'b00, '0);
      guard++;
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL b2b_drain cyc=%0d got=%b want=%b", guard, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 2'b10, 4'd8);
    step(1'b1, 2'b01, 4'd2);
    step(1'b1, 2'b11, 4'd1);
    step(1'b0, 2'b00, '0);
    step(1'b0, 2'b00, '0);
    tests++;
    if ({j, k, busy} !== 3'b101) begin
      fails++;
      $display("FAIL midcmd_pre got=%b want=%b", {j, k, busy}, 3'b101);
    end
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    tests++;
    if ({j, k, done, busy, cmd_ready, err} !== 6'b000010) begin
      fails++;
      $display("FAIL midcmd_async got=%b want=%b", {j, k, done, busy, cmd_ready, err}, 6'b000010);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b00, '0);
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL midcmd_after cyc=%0d got=%b want=%b", i, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic v;
    int guard;
    for (int i = 0; i < 400; i++) begin
`ifndef JKSEQ_CHECK_EN
      inject = 1'($urandom);
`endif
      v = ($urandom_range(0, 99) < 55);
      step(v, 2'($urandom), 4'($urandom_range(0, 5)));
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL random cyc=%0d got=%b want=%b", i, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
    guard = 0;
    while ((m_rem > 0 || mq.size() > 0) && guard < 100) begin
      step(1'b0, 2'b00, '0);
      guard++;
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL random_drain cyc=%0d got=%b want=%b", guard, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
    end
    inject = 1'b0;
  endtask

`ifdef JKSEQ_CHECK_EN
  task automatic test_err_sticky();
    step(1'b1, 2'b10, 4'd4);
    step(1'b0, 2'b00, '0);
    step(1'b0, 2'b00, '0);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_before got=%b want=0", err);
    end
    inject = 1'b1;
    step(1'b0, 2'b00, '0);
    inject = 1'b0;
    m_err = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if ({j, k, done, busy, cmd_ready, err} !== exp_vec()) begin
        fails++;
        $display("FAIL err_sticky cyc=%0d got=%b want=%b", i, {j, k, done, busy, cmd_ready, err}, exp_vec());
      end
      step(1'b0, 2'b00, '0);
    end
    rst = 1'b1;
    m_reset();
    #1;
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_clear got=%b want=0", err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_len3();
    test_toggle_len0();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef JKSEQ_CHECK_EN
    test_err_sticky();
    test_random();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
